muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit for the execute stage, alongside the ALU and sharing its A/B operand buses. It owns the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU with a start/busy/done handshake, and MTHI/MTLO in a single cycle. The stall logic holds the pipeline on `busy`. MFHI/MFLO read `hi`/`lo` directly.

## Interface
Parameters:
- none; datapath is fixed at 32 bits.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `A`  in  32  operand A: multiplicand, dividend, or MTHI/MTLO source.
- `B`  in  32  operand B: multiplier or divisor.
- `op`  in  3  operation:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
  - 110/111 reserved; treated as no-op.
- `start`  in  1  request; sampled only when `busy`=0.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse; results committed to `hi`/`lo` on the same edge.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `div_zero`  out  1  last accepted divide had B=0; holds until the next accepted start.

## Operation
- States: IDLE, RUN. A 6-bit iteration counter `cnt` is used in RUN.
- IDLE, `start`=1:
  - MTHI: hi←A, `done`=1, stay IDLE.
  - MTLO: lo←A, `done`=1, stay IDLE.
  - Reserved op: `done`=1, no register change.
  - DIV/DIVU with B=0:
    - hi/lo unchanged, `div_zero`←1, `done`=1, stay IDLE.
  - MULT/MULTU/DIV/DIVU otherwise:
    - Latch operand magnitudes and result-sign flags; clear `div_zero`; `cnt`←0; go to RUN; `busy`←1.
    - Signed ops take |A| and |B|.
    - Unsigned ops use the raw values.
- RUN, one iteration per cycle:
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; one quotient bit per cycle.
  - Iteration 31 (`cnt`=31):
    - Apply sign correction and write hi/lo.
    - `busy`←0, `done`←1, return to IDLE.
- Result rules:
  - MULT/MULTU: {hi,lo} = 64-bit product; sign = A[31]^B[31] for MULT.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - DIV signs: quotient sign = A[31]^B[31]; remainder sign = dividend sign.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. This is the natural 32-bit wrap; no trap.
- Boundary conditions:
  - `start` while `busy`=1 is ignored; operands and op are not resampled.
  - `A`/`B`/`op` may change after acceptance without effect.
- hi/lo change only on a `done` edge. They are never partially updated during RUN.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_zero`=0, state=IDLE.
- Reset asserted mid-RUN aborts the operation with no `done` pulse.
- Iterative operation latency:
  - Accept edge E0 sets `busy`=1.
  - Edges E1..E32 iterate; E32 commits hi/lo and sets `done`=1, `busy`=0.
  - Results are visible the cycle after E32.
- Single-cycle operations (MTHI, MTLO, divide-by-zero, reserved):
  - The accept edge commits and pulses `done`.
  - `busy` never rises.
- Back-to-back: a new `start` is accepted on the edge after E32, i.e. the cycle in which `done`=1.
- `done` is registered and high for exactly one cycle.

## Configuration
- `MULDIV_DIV_EN` defined: divider datapath compiled in; DIV/DIVU behave as above.
- `MULDIV_DIV_EN` undefined: divider removed.
  - DIV/DIVU complete on the accept edge with `done`=1, hi/lo unchanged, and `div_zero`=0 regardless of B.
  - Multiply and MTHI/MTLO are unaffected.

## Test plan
- MULT A=0xFFFFFFFD (−3), B=7 → `done` at E32; hi=0xFFFFFFFF, lo=0xFFFFFFEB; `busy` high for exactly 32 cycles.
- MULTU A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV A=0xFFFFFFF9 (−7), B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU A=100, B=7 → lo=14, hi=2.
- DIVU A=5, B=0 with hi/lo preloaded via MTHI=0x11, MTLO=0x22 → `done` on the accept edge, `div_zero`=1, hi=0x11, lo=0x22, `busy` never asserted.
- Start MULT 3×4; pulse `start` with op=MTLO, A=0xDEAD at cycle 10 → ignored; after E32 lo=12, hi=0.
- Start DIVU; assert `rst` at cycle 15 → next cycle `busy`=0, hi=lo=0, no `done` pulse; a MULT 2×2 started afterwards yields lo=4.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning the architectural HI/LO registers.
// Optional divider datapath: define MULDIV_DIV_EN to compile it in; otherwise DIV/DIVU complete as no-ops.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  localparam int unsigned W = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_DIVU = 3'b011;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_d;

  logic [2*W-1:0] acc, acc_d;
  logic [W-1:0]   opnd, opnd_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           neg, neg_d;
  logic [W-1:0]   hi_d, lo_d;
  logic           done_d, dz_d;
`ifdef MULDIV_DIV_EN
  logic           is_div, is_div_d;
  logic           neg_r, neg_r_d;
`endif

  logic           is_mul_c, is_div_ok_c, signed_c, launch_c;
  logic [W-1:0]   mag_a_c, mag_b_c;
  logic [2*W-1:0] init_acc_c;
  logic [W-1:0]   init_opnd_c;
  logic [W:0]     mul_sum_c;
  logic [2*W-1:0] mul_step_c, step_c, mul_res_c;
  logic [W-1:0]   res_hi_c, res_lo_c;

  // Operation decode and operand magnitudes for the launch cycle
  assign is_mul_c = (op[2:1] == 2'b00);
  assign signed_c = ~op[0];
  assign mag_a_c  = (signed_c && A[W-1]) ? -A : A;
  assign mag_b_c  = (signed_c && B[W-1]) ? -B : B;
`ifdef MULDIV_DIV_EN
  assign is_div_ok_c = (op[2:1] == 2'b01) && (B != 32'd0);
  assign init_acc_c  = is_mul_c ? {32'd0, mag_b_c} : {32'd0, mag_a_c};
  assign init_opnd_c = is_mul_c ? mag_a_c : mag_b_c;
`else
  assign is_div_ok_c = 1'b0;
  assign init_acc_c  = {32'd0, mag_b_c};
  assign init_opnd_c = mag_a_c;
`endif
  assign launch_c = start && (state == IDLE) && (is_mul_c || is_div_ok_c);

  assign busy = (state == RUN);

  // Multiply: add multiplicand into the upper half when the LSB is set, then shift right
  assign mul_sum_c  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_step_c = {mul_sum_c, acc[W-1:1]};
  assign mul_res_c  = neg ? -step_c : step_c;

`ifdef MULDIV_DIV_EN
  // Restoring divide: {remainder, quotient/dividend} shifts left one bit per cycle
  logic [W:0]     div_trial_c;
  logic [2*W-1:0] div_step_c;
  assign div_trial_c = acc[2*W-1:W-1] - {1'b0, opnd};
  assign div_step_c  = div_trial_c[W] ? {acc[2*W-2:0], 1'b0}
                                      : {div_trial_c[W-1:0], acc[W-2:0], 1'b1};
  assign step_c   = is_div ? div_step_c : mul_step_c;
  assign res_lo_c = is_div ? (neg ? -step_c[W-1:0] : step_c[W-1:0]) : mul_res_c[W-1:0];
  assign res_hi_c = is_div ? (neg_r ? -step_c[2*W-1:W] : step_c[2*W-1:W]) : mul_res_c[2*W-1:W];
`else
  assign step_c   = mul_step_c;
  assign res_lo_c = mul_res_c[W-1:0];
  assign res_hi_c = mul_res_c[2*W-1:W];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (launch_c) state_d = RUN;
      RUN:     if (cnt == LAST_ITER) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    hi_d     = hi;
    lo_d     = lo;
    done_d   = 1'b0;
    dz_d     = div_zero;
    acc_d    = acc;
    opnd_d   = opnd;
    neg_d    = neg;
    cnt_d    = cnt;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div;
    neg_r_d  = neg_r;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          dz_d = 1'b0;
          if (launch_c) begin
            cnt_d    = '0;
            acc_d    = init_acc_c;
            opnd_d   = init_opnd_c;
            neg_d    = signed_c & (A[W-1] ^ B[W-1]);
`ifdef MULDIV_DIV_EN
            is_div_d = ~is_mul_c;
            neg_r_d  = signed_c & A[W-1];
`endif
          end else begin
            done_d = 1'b1;
            case (op)
              OP_MTHI: hi_d = A;
              OP_MTLO: lo_d = A;
`ifdef MULDIV_DIV_EN
              OP_DIV, OP_DIVU: dz_d = 1'b1;
`endif
              default: ;
            endcase
          end
        end
      end
      RUN: begin
        acc_d = step_c;
        cnt_d = cnt + 6'd1;
        if (cnt == LAST_ITER) begin
          done_d = 1'b1;
          hi_d   = res_hi_c;
          lo_d   = res_lo_c;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
`ifdef MULDIV_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      hi       <= hi_d;
      lo       <= lo_d;
      done     <= done_d;
      div_zero <= dz_d;
      acc      <= acc_d;
      opnd     <= opnd_d;
      neg      <= neg_d;
      cnt      <= cnt_d;
`ifdef MULDIV_DIV_EN
      is_div   <= is_div_d;
      neg_r    <= neg_r_d;
`endif
    end
  end

endmodule
